complex_mac_array_param: RTL
============================

Name: complex_mac_array_param

Overview:
- Parametrised successor to the fixed 4x4x4 complex multiply and accumulate arrays in the convolution computation engine.
- Multiplies TILES image tiles, each ROWS x COLS complex fixed-point elements, element-wise by one shared kernel tile.
- Accumulates the products over a runtime-configured number of beats (input channels).
- Returns one accumulated result set per job over a valid/ready handshake. Sits between the FFT tile buffers and the inverse-FFT/output stage.

Parameters:
TILES, 4, parallel image tiles sharing one kernel
ROWS, 4, tile rows
COLS, 4, tile columns
DATA_W, 16, signed width of each real/imag input component
ACC_W, 40, signed width of each real/imag accumulator component; must be >= 2*DATA_W+1
CNT_W, 8, width of the beat-count configuration

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  job start pulse, sampled only in IDLE
cfg_depth  in  CNT_W  beats to accumulate for this job, latched on accepted start
busy  out  1  high in any state other than IDLE
in_valid  in  1  image/kernel beat valid
in_ready  out  1  beat accept; high only in ACCUM
image  in  TILES*ROWS*COLS*2*DATA_W  packed image beat
kernel  in  ROWS*COLS*2*DATA_W  packed kernel beat, shared by all tiles
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_data  out  TILES*ROWS*COLS*2*ACC_W  packed accumulated results
overflow  out  1  sticky saturation flag (optional feature)

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (reset).
- Packing: element index e=(t*ROWS+r)*COLS+c. Real part at [e*2W +: W], imag at [e*2W+W +: W], where W is DATA_W for inputs and ACC_W for outputs. Kernel uses e=r*COLS+c.
- Arithmetic, per element:
  - re = ar*br - ai*bi; im = ar*bi + ai*br.
  - Computed signed at 2*DATA_W+1 bits, sign-extended to ACC_W, added to the accumulator.
  - Default accumulation wraps modulo 2^ACC_W.
- Pipeline:
  - Stage 1 registers the four partial products per element.
  - Stage 2 registers the re/im sums.
  - The accumulator register adds on the following edge.
  - A valid bit travels with each stage.
- FSM, IDLE -> ACCUM -> DRAIN -> OUT -> IDLE:
  - IDLE: in_ready=0, out_valid=0.
    - start=1 with cfg_depth!=0: latch depth, clear all accumulators, clear overflow, go to ACCUM.
    - start with cfg_depth==0: ignored, stay in IDLE.
  - ACCUM: in_ready=1. Each in_valid&in_ready edge increments the beat counter. When the beat being accepted is number depth: go to DRAIN. A gap in in_valid simply stalls.
  - DRAIN: in_ready=0. Wait until no pipeline stage holds a valid beat, then go to OUT.
  - OUT: out_valid=1 and out_data is stable until an out_ready edge, then go to IDLE.
- Latency: out_valid rises 3 clocks after the edge that accepts the final beat (depth 1 included).
- out_data:
  - Continuously driven from the accumulator registers.
  - Meaningful only while out_valid=1.
  - Must not change while out_valid=1 and out_ready=0.
- start outside IDLE is ignored, with no effect on the running job.
- Reset (any state, including mid-job or mid-OUT), on the next edge:
  - state=IDLE, busy=0, in_ready=0, out_valid=0, overflow=0.
  - Pipeline valids cleared, beat counter=0, accumulators=0.
- Depth 2^CNT_W-1 must work without counter wrap; counter width is CNT_W.

Optional Feature:
Macro: COMPLEX_MAC_SAT_EN
- Defined:
  - Each accumulator component saturates to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) instead of wrapping.
  - Any saturation event sets overflow, which stays set until the next accepted start or reset.
- Undefined:
  - Accumulation wraps.
  - overflow is tied to 0; the port is always present.

Test Plan:
- Depth 1: all image elements 1+2j, kernel elements 3+4j, depth=1 -> out_valid 3 cycles after accept; every element -5+10j.
- Depth 4 with in_valid gaps: image 1+0j, kernel 0+1j, depth=4, beats on cycles 0,2,3,7 -> every element 0+4j; in_ready=0 during DRAIN/OUT.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid stays 1 and out_data is unchanged. Assert out_ready -> IDLE on the next edge; busy=0.
- Ignored commands: start with cfg_depth=0 -> stays IDLE, busy=0. start asserted during ACCUM -> the job completes with its original depth.
- Mid-job reset: depth=8, reset after 3 beats -> outputs at reset values. A new depth=1 job then gives a fresh result with no residue.
- Overflow, ACC_W=33, DATA_W=16: image and kernel -32768+0j, depth=4 -> wrap result without the macro. With COMPLEX_MAC_SAT_EN: re saturates to 2^32-1 and overflow=1.

Source files
------------

// File: rtl/complex_mac_array_param.sv
// Element-wise complex MAC of TILES image tiles against one shared kernel tile, accumulated over cfg_depth beats.
// Latency: out_valid rises 3 clocks after the edge accepting the final beat; 2 pipeline stages then the accumulator.
// Backpressure: in_ready only in ACCUM; results held stable in OUT until out_ready. Saturation: COMPLEX_MAC_SAT_EN.
module complex_mac_array_param #(
    parameter int TILES  = 4,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [CNT_W-1:0]                    cfg_depth,
    output logic                                busy,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [TILES*ROWS*COLS*2*DATA_W-1:0] image,
    input  logic [ROWS*COLS*2*DATA_W-1:0]       kernel,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [TILES*ROWS*COLS*2*ACC_W-1:0]  out_data,
    output logic                                overflow
);
    localparam int KE = ROWS * COLS;
    localparam int NE = TILES * KE;
    localparam int PW = 2 * DATA_W;
    localparam int SW = 2 * DATA_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   depth_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               s1_vld_q;
    logic               s2_vld_q;
    logic               accept;
    logic               clr_acc;

    assign accept    = in_valid & in_ready_q;
    assign clr_acc   = (state_q == S_IDLE) & start & (cfg_depth != '0);
    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            depth_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
            case (state_q)
                S_IDLE: begin
                    if (clr_acc) begin
                        depth_q    <= cfg_depth;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    // Compare against depth-1 so depth 2^CNT_W-1 never needs the counter to wrap.
                    if (accept) begin
                        if (cnt_q == depth_q - CNT_W'(1)) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!s1_vld_q && !s2_vld_q) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef COMPLEX_MAC_SAT_EN
    logic [NE-1:0] sat_hit;
    logic          ovf_q;

    // Returns {saturated, value}; overflow shows as the two top bits of the widened sum differing.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        end else begin
            sat_add = {1'b0, s[ACC_W-1:0]};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clr_acc) begin
            ovf_q <= 1'b0;
        end else if (|sat_hit) begin
            ovf_q <= 1'b1;
        end
    end
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    for (genvar e = 0; e < NE; e++) begin : g_el
        localparam int K = e % KE;
        logic signed [DATA_W-1:0] ar, ai, br, bi;
        logic signed [PW-1:0]     rr_q, ii_q, ri_q, ir_q;
        logic signed [SW-1:0]     re_q, im_q;
        logic signed [ACC_W-1:0]  add_re, add_im;
        logic signed [ACC_W-1:0]  acc_re_q, acc_im_q, acc_re_d, acc_im_d;

        assign ar = image[e*2*DATA_W +: DATA_W];
        assign ai = image[e*2*DATA_W+DATA_W +: DATA_W];
        assign br = kernel[K*2*DATA_W +: DATA_W];
        assign bi = kernel[K*2*DATA_W+DATA_W +: DATA_W];

        assign add_re = ACC_W'(re_q);
        assign add_im = ACC_W'(im_q);

`ifdef COMPLEX_MAC_SAT_EN
        logic sat_re, sat_im;
        assign {sat_re, acc_re_d} = sat_add(acc_re_q, add_re);
        assign {sat_im, acc_im_d} = sat_add(acc_im_q, add_im);
        assign sat_hit[e] = s2_vld_q & (sat_re | sat_im);
`else
        assign acc_re_d = acc_re_q + add_re;
        assign acc_im_d = acc_im_q + add_im;
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                rr_q     <= '0;
                ii_q     <= '0;
                ri_q     <= '0;
                ir_q     <= '0;
                re_q     <= '0;
                im_q     <= '0;
                acc_re_q <= '0;
                acc_im_q <= '0;
            end else begin
                if (accept) begin
                    rr_q <= PW'(ar) * PW'(br);
                    ii_q <= PW'(ai) * PW'(bi);
                    ri_q <= PW'(ar) * PW'(bi);
                    ir_q <= PW'(ai) * PW'(br);
                end
                if (s1_vld_q) begin
                    re_q <= SW'(rr_q) - SW'(ii_q);
                    im_q <= SW'(ri_q) + SW'(ir_q);
                end
                if (clr_acc) begin
                    acc_re_q <= '0;
                    acc_im_q <= '0;
                end else if (s2_vld_q) begin
                    acc_re_q <= acc_re_d;
                    acc_im_q <= acc_im_d;
                end
            end
        end

        assign out_data[e*2*ACC_W +: ACC_W]       = acc_re_q;
        assign out_data[e*2*ACC_W+ACC_W +: ACC_W] = acc_im_q;
    end
endmodule
